// File: rtl/dm_arbiter.sv
// Two-way round-robin arbiter and one-shot sequencer for the shared data
// memory port. A grant takes three cycles: handshake (IDLE), one memory
// access (ACCESS), and a registered one-cycle response (RESP).
module dm_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [1:0]      req_we,
  input  logic [5:0]      req_mode,
  input  logic [2*AW-1:0] req_addr,
  input  logic [2*DW-1:0] req_wdata,
  output logic [1:0]      resp_valid,
  output logic [DW-1:0]   resp_rdata,
  output logic            resp_err,
  output logic            mem_r,
  output logic            mem_wr,
  output logic [1:0]      mem_wr_bits,
  output logic [2:0]      mem_r_bits,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t          state, state_nxt;
  logic            last_grant;
  logic            grant;
  logic            winner;
  logic            any_valid;
  logic            sel_we;
  logic [2:0]      sel_mode;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;
  logic            sel_err;
  logic            lat_we;
  logic            lat_err;
  logic [2:0]      lat_mode;
  logic [AW-1:0]   lat_addr;
  logic [DW-1:0]   lat_wdata;
  logic            access_ok;

  // Round-robin pick: with both valid the requester not served last wins.
  always_comb begin
    any_valid = |req_valid;
    winner    = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
    sel_we    = winner ? req_we[1]               : req_we[0];
    sel_mode  = winner ? req_mode[5:3]           : req_mode[2:0];
    sel_addr  = winner ? req_addr[2*AW-1:AW]     : req_addr[AW-1:0];
    sel_wdata = winner ? req_wdata[2*DW-1:DW]    : req_wdata[DW-1:0];
  end

  // Alignment and mode legality of the winning request.
  always_comb begin
    sel_err = 1'b0;
    if (sel_we) begin
      unique case (sel_mode[1:0])
        2'b00:   sel_err = |sel_addr[1:0];
        2'b01:   sel_err = sel_addr[0];
        2'b10:   sel_err = 1'b0;
        default: sel_err = 1'b1;
      endcase
    end else begin
      case (sel_mode)
        3'b000:        sel_err = |sel_addr[1:0];
        3'b001, 3'b010: sel_err = sel_addr[0];
        3'b011, 3'b100: sel_err = 1'b0;
        default:       sel_err = 1'b1;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (any_valid) state_nxt = ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch and grant bookkeeping at the handshake edge.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      last_grant <= 1'b1;
      grant      <= 1'b0;
      lat_we     <= 1'b0;
      lat_err    <= 1'b0;
      lat_mode   <= '0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
    end else if (state == IDLE && any_valid) begin
      last_grant <= winner;
      grant      <= winner;
      lat_we     <= sel_we;
      lat_err    <= sel_err;
      lat_mode   <= sel_mode;
      lat_addr   <= sel_addr;
      lat_wdata  <= sel_wdata;
    end
  end

  // Registered response: captured during ACCESS, presented during RESP.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      resp_valid <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else if (state == ACCESS) begin
      resp_valid <= grant ? 2'b10 : 2'b01;
      resp_rdata <= (!lat_err && !lat_we) ? mem_rdata : '0;
      resp_err   <= lat_err;
    end else begin
      resp_valid <= '0;
    end
  end

  // Handshake and memory pin drive; write enable also gated by rstn so a
  // reset landing in ACCESS cannot commit a write.
  always_comb begin
    access_ok   = (state == ACCESS) && !lat_err;
    req_ready   = '0;
    if (state == IDLE && any_valid) req_ready = winner ? 2'b10 : 2'b01;
    mem_r       = access_ok && !lat_we;
    mem_wr      = access_ok && lat_we && rstn;
    mem_r_bits  = (access_ok && !lat_we) ? lat_mode      : '0;
    mem_wr_bits = (access_ok && lat_we)  ? lat_mode[1:0] : '0;
    mem_addr    = access_ok ? lat_addr : '0;
    mem_wdata   = (access_ok && lat_we) ? lat_wdata : '0;
  end

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Sequencer and two-way arbiter for the shared data memory port.
- Requester 0 is the CPU memory stage; requester 1 is a DMA/debug loader.
- Grants one request at a time by round-robin, checks alignment and the access mode, and drives the data memory control/address/data pins for exactly one cycle.
- Returns read data or an error to the granted requester as a single-cycle response.

Parameters:
- AW, 32, address width of requests and of mem_addr.
- DW, 32, data width (fixed at 32; byte lanes assume 4 bytes per word).

Ports:
- clk  in  1  rising-edge clock
- rstn  in  1  synchronous active-low reset
- req_valid  in  2  bit i = requester i has a request
- req_ready  out  2  bit i = request i accepted this cycle (valid&ready = handshake)
- req_we  in  2  bit i: 1 = write, 0 = read
- req_mode  in  6  [3i+2:3i]; read: 000 lw, 001 lhu, 010 lh, 011 lbu, 100 lb; write uses low 2 bits: 00 sw, 01 sh, 10 sb
- req_addr  in  2*AW  [AW*i+AW-1:AW*i] byte address
- req_wdata  in  2*DW  write data, right-aligned (sh uses [15:0], sb uses [7:0])
- resp_valid  out  2  bit i = one-cycle response to requester i
- resp_rdata  out  DW  read data (0 for writes and errors)
- resp_err  out  1  qualifies resp_valid: misaligned or illegal mode
- mem_r  out  1  data memory read enable
- mem_wr  out  1  data memory write enable
- mem_wr_bits  out  2  write size, same encoding as the write mode
- mem_r_bits  out  3  read mode, same encoding as the read mode
- mem_addr  out  AW  byte address
- mem_wdata  out  DW  write data
- mem_rdata  in  DW  combinational read data from memory

Behaviour:
- FSM states: IDLE, ACCESS, RESP. Reset state is IDLE.
- Reset values: req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, all mem_* outputs 0, last_grant=1 (requester 0 wins first).
- IDLE:
  - If any req_valid bit is set, pick the winner. With both valid, the winner is the requester other than last_grant; otherwise the single valid one.
  - req_ready[winner]=1 combinationally in this cycle only. At most one ready bit is ever set.
  - At the clock edge: latch we/mode/addr/wdata, set last_grant=winner, compute err, go to ACCESS.
- Err rules:
  - Word (sw/lw) requires addr[1:0]=00.
  - Half (sh/lh/lhu) requires addr[0]=0.
  - Byte accesses never fault.
  - Read modes 101–111 and write mode 11 are illegal.
- ACCESS (exactly 1 cycle):
  - If err=0: mem_r=~we, mem_wr=we, mem_r_bits/mem_wr_bits/mem_addr/mem_wdata driven from the latched request. Memory commits the write at the end of this cycle.
  - resp_rdata register captures mem_rdata for reads, 0 for writes.
  - If err=1: mem_r=mem_wr=0 and resp_rdata captures 0.
  - Next state: RESP.
- RESP:
  - resp_valid[grant]=1 for one cycle, with resp_rdata/resp_err held.
  - No new grant in this cycle; next state is IDLE.
  - Throughput is one transaction per 3 cycles; latency from handshake to resp_valid is 2 cycles.
- mem_* outputs are 0 in IDLE and RESP.
- mem_wr is additionally gated by rstn combinationally, so a reset asserted during ACCESS commits no write.
- Reset mid-transaction: return to IDLE, no response issued, last_grant=1.
- Requesters hold their fields stable only up to the handshake. A requester dropping valid before being granted is legal and is simply not granted.
- resp_valid, resp_rdata and resp_err are registered. req_ready is combinational from state and req_valid only; there is no path from resp to req.

Test Plan:
- Reset, then requester 0 issues sw addr=0x10 wdata=0xDEADBEEF, followed by lw addr=0x10.
  - Required: req_ready[0] in cycle 0, mem_wr=1 with mem_addr=0x10 in cycle 1, resp_valid[0] in cycle 2.
  - The lw response has resp_rdata=0xDEADBEEF and resp_err=0.
- Both requesters valid continuously with reads.
  - Required: grants alternate 0,1,0,1.
  - resp_valid pulses every 3 cycles, one bit at a time.
- Memory word 0x20 preset to 0x80F0_7F01.
  - lb 0x23 → 0xFFFFFF80.
  - lbu 0x23 → 0x00000080.
  - lh 0x22 → 0xFFFF80F0.
  - lhu 0x20 → 0x00007F01.
- Write faults: sw addr=0x12, sh addr=0x11, write mode 11.
  - Required: resp_err=1, resp_rdata=0, mem_wr stays 0 throughout; a subsequent lw confirms memory is unchanged.
- Read faults: lw addr=0x13 and read mode 101.
  - Required: resp_err=1 and mem_r stays 0.
- rstn driven low during the ACCESS cycle of sb addr=0x31 data=0xAA.
  - Required: no write (word 0x30 unchanged) and no resp_valid.
  - After release, requester 0 is granted first.
